pc_redirect_ctrl: RTL and testbench

Fetch-side program-counter controller. It consumes branch and jump resolution from the ID stage and keeps the PC register. It produces the fetch PC, PC+4, and the IF/ID flush.
- It is the producer end of the next-PC select path: it owns the sequencing.
- Sequencing covers start-up, stalls, redirects, and suppression of branch signals coming from squashed instructions.
- Sits between the hazard unit / ID-stage branch logic and the instruction memory.

---
 rtl/pc_ctrl_pkg.sv | 24 ++
 rtl/pc_redirect_stats.sv | 34 +++
 rtl/pc_redirect_ctrl.sv | 107 ++++++++++
 tb/tb_pc_redirect_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// +-----------------------------------------------------------------------+
// | pc_ctrl_pkg : shared types and constants for the fetch PC controller  |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
`default_nettype none

package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SHADOW = 2'd2
    } pc_state_e;

    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_redirect_stats.sv
// +-----------------------------------------------------------------------+
// | pc_redirect_stats : bank of saturating event counters (taken/jump/    |
// | stall), cleared by reset. Revision : 1.0                              |
// +-----------------------------------------------------------------------+
`default_nettype none

module pc_redirect_stats (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  inc_i,
    output logic [31:0] taken_cnt_o,
    output logic [31:0] jump_cnt_o,
    output logic [31:0] stall_cnt_o
);

    logic [2:0][31:0] cnt_q;

    for (genvar g = 0; g < 3; g++) begin : g_cnt
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                cnt_q[g] <= '0;
            end else if (inc_i[g] && (cnt_q[g] != '1)) begin
                cnt_q[g] <= cnt_q[g] + 32'd1;
            end
        end
    end

    assign taken_cnt_o = cnt_q[0];
    assign jump_cnt_o  = cnt_q[1];
    assign stall_cnt_o = cnt_q[2];

endmodule

`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
// +-----------------------------------------------------------------------+
// | pc_redirect_ctrl : fetch PC register with start, stall and redirect   |
// | sequencing. Optional counters via PC_REDIRECT_STATS_EN. Revision 1.0  |
// +-----------------------------------------------------------------------+
`default_nettype none

module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        Branch_i,
    input  logic        Zero_i,
    input  logic [31:0] target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic        flush_o
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [31:0] taken_cnt_o,
    output logic [31:0] jump_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    pc_state_e   state_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        take;
    logic        redirect;
    logic [31:0] redirect_pc;

    assign take        = jump_i | (Branch_i & Zero_i);
    // Branch signals only mean something in RUN without a stall.
    assign redirect    = (state_q == ST_RUN) && !stall_i && take;
    assign redirect_pc = align_word(jump_i ? jump_addr_i : target_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        valid_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!stall_i) begin
                        if (take) begin
                            pc_q    <= redirect_pc;
                            state_q <= ST_SHADOW;
                        end else begin
                            pc_q    <= pc_q + INSTR_BYTES;
                        end
                    end
                end
                ST_SHADOW: begin
                    if (!stall_i) begin
                        pc_q    <= pc_q + INSTR_BYTES;
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pc_q    <= RESET_PC;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + INSTR_BYTES;
    assign valid_o    = valid_q;
    assign flush_o    = redirect;

`ifdef PC_REDIRECT_STATS_EN
    logic [2:0] stat_inc;

    assign stat_inc[0] = redirect && !jump_i;
    assign stat_inc[1] = redirect && jump_i;
    assign stat_inc[2] = (state_q != ST_IDLE) && stall_i;

    pc_redirect_stats u_stats (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (stat_inc),
        .taken_cnt_o (taken_cnt_o),
        .jump_cnt_o  (jump_cnt_o),
        .stall_cnt_o (stall_cnt_o)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_pc_redirect_ctrl : directed + random scoreboard bench for the      |
// | fetch PC controller. Revision : 1.0                                   |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_pc_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, stall_i, Branch_i, Zero_i, jump_i;
    logic [31:0] target_i, jump_addr_i;
    logic [31:0] pc_o, pc_plus4_o;
    logic        valid_o, flush_o;
`ifdef PC_REDIRECT_STATS_EN
    logic [31:0] taken_cnt_o, jump_cnt_o, stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    pc_redirect_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .stall_i     (stall_i),
        .Branch_i    (Branch_i),
        .Zero_i      (Zero_i),
        .target_i    (target_i),
        .jump_i      (jump_i),
        .jump_addr_i (jump_addr_i),
        .pc_o        (pc_o),
        .pc_plus4_o  (pc_plus4_o),
        .valid_o     (valid_o),
        .flush_o     (flush_o)
`ifdef PC_REDIRECT_STATS_EN
        ,
        .taken_cnt_o (taken_cnt_o),
        .jump_cnt_o  (jump_cnt_o),
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        flush;
        logic [31:0] n_taken;
        logic [31:0] n_jump;
        logic [31:0] n_stall;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   drv_done = 1'b0;

    // Reference model: fetching-started flag, "next cycle is the squashed bubble" flag, PC, tallies.
    bit          m_started;
    bit          m_bubble;
    logic [31:0] m_pc;
    logic [31:0] m_taken, m_jump, m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_bubble  = 1'b0;
        m_pc      = RST_PC;
        m_taken   = '0;
        m_jump    = '0;
        m_stall   = '0;
    endtask

    task automatic cycle(input bit rstn, input bit st, input bit stl, input bit br, input bit z,
                         input logic [31:0] tgt, input bit j, input logic [31:0] ja);
        exp_t e;
        bit   redirect;
        @(negedge clk_i);
        rst_i = rstn; start_i = st; stall_i = stl; Branch_i = br; Zero_i = z;
        target_i = tgt; jump_i = j; jump_addr_i = ja;
        if (!rstn) model_reset();
        redirect = rstn && m_started && !m_bubble && !stl && (j || (br && z));
        e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.valid = m_started; e.flush = redirect;
        e.n_taken = m_taken; e.n_jump = m_jump; e.n_stall = m_stall;
        sb.push_back(e);
        if (rstn) begin
            if (!m_started) begin
                m_started = st;
            end else begin
                if (stl) m_stall = sat_inc(m_stall);
                if (!stl) begin
                    if (redirect) begin
                        if (j) m_jump = sat_inc(m_jump);
                        else   m_taken = sat_inc(m_taken);
                        m_pc     = (j ? ja : tgt) & 32'hFFFF_FFFC;
                        m_bubble = 1'b1;
                    end else begin
                        m_pc     = m_pc + 32'd4;
                        m_bubble = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents pc/valid/flush; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (sb.size() == 0) begin
                if (!drv_done) chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("pc_o", pc_o, e.pc);
                chk("pc_plus4_o", pc_plus4_o, e.pc4);
                chk("valid_o", {31'd0, valid_o}, {31'd0, e.valid});
                chk("flush_o", {31'd0, flush_o}, {31'd0, e.flush});
`ifdef PC_REDIRECT_STATS_EN
                chk("taken_cnt_o", taken_cnt_o, e.n_taken);
                chk("jump_cnt_o", jump_cnt_o, e.n_jump);
                chk("stall_cnt_o", stall_cnt_o, e.n_stall);
`endif
            end
        end
    end

    initial begin
        rst_i = 1'b0; start_i = 0; stall_i = 0; Branch_i = 0; Zero_i = 0;
        target_i = 0; jump_i = 0; jump_addr_i = 0;
        model_reset();

        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 32'h80, 1, 32'h90);      // idle ignores redirects
        cycle(1, 1, 0, 0, 0, 0, 0, 0);                // start
        run(4);                                        // 0x0 .. 0xC
        cycle(1, 0, 0, 1, 1, 32'h40, 0, 0);           // taken at 0x10
        cycle(1, 0, 0, 1, 1, 32'h80, 0, 0);           // ignored in shadow
        run(1);
        cycle(1, 0, 0, 0, 0, 0, 1, 32'h1C);
        run(1);                                        // shadow 0x1C -> 0x20
        cycle(1, 0, 0, 1, 0, 32'h60, 0, 0);           // not-taken at 0x20
        cycle(1, 0, 0, 0, 0, 0, 1, 32'h2C);
        run(1);
        cycle(1, 0, 1, 0, 0, 0, 1, 32'h100);          // stall beats jump at 0x30
        cycle(1, 0, 1, 0, 0, 0, 1, 32'h100);
        cycle(1, 0, 0, 0, 0, 0, 1, 32'h100);
        run(1);
        cycle(1, 0, 0, 1, 1, 32'h300, 1, 32'h200);    // jump wins
        run(1);
        cycle(1, 0, 0, 1, 1, 32'h47, 0, 0);           // misaligned target
        cycle(1, 0, 1, 0, 0, 0, 0, 0);                // stall inside shadow
        cycle(0, 0, 0, 0, 0, 0, 0, 0);                // reset in shadow
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF8);
        run(3);                                        // wrap through 0
        cycle(1, 1, 0, 0, 0, 0, 0, 0);                // start outside idle

        for (int i = 0; i < 2000; i++) begin
            bit rn, st, stl, br, z, j;
            logic [31:0] tgt, ja;
            rn  = ($urandom_range(99) >= 2);
            st  = ($urandom_range(99) < 30);
            stl = ($urandom_range(99) < 25);
            br  = ($urandom_range(99) < 35);
            z   = $urandom_range(1) == 1;
            j   = ($urandom_range(99) < 15);
            tgt = $urandom;
            ja  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            cycle(rn, st, stl, br, z, tgt, j, ja);
        end

        #3;
        drv_done = 1'b1;
        if (sb.size() != 0) chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
